// File: rtl/mux16_scan_ctrl.sv
// rtl/mux16_scan_ctrl.sv - steps a 16:1 mux select, samples each input and returns a 16-bit word (optional MUX_SCAN_PARITY_EN)
module mux16_scan_ctrl #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        mux_out,
    output logic [3:0]  sel,
    output logic        busy,
    output logic [15:0] word,
    output logic        word_valid,
    input  logic        word_ready
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic        parity
`endif
);

    // Settle counter reload value; with zero settle cycles the SETTLE state is never entered.
    localparam bit         HAS_SETTLE  = (SETTLE_CYCLES > 0);
    localparam logic [3:0] SETTLE_LOAD = HAS_SETTLE ? 4'(SETTLE_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  sel_next;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic [15:0] shreg;
    logic [15:0] shreg_next;
    logic [15:0] captured;
    logic [15:0] word_next;
    logic        valid_next;
    logic        step_state;

`ifdef MUX_SCAN_PARITY_EN
    logic        parity_next;
`endif

    // State entered after a select step completes (or a scan starts).
    assign step_state = HAS_SETTLE;

    // Busy covers the whole scan: every settle and sample cycle.
    assign busy = (state == ST_SETTLE) || (state == ST_SAMPLE);

    // Capture register with the current mux output inserted at the current select position.
    always_comb begin
        captured      = shreg;
        captured[sel] = mux_out;
    end

    // Next-state and datapath decode; abort wins over sampling and drops the bit in flight.
    always_comb begin
        state_next = state;
        sel_next   = sel;
        cnt_next   = cnt;
        shreg_next = shreg;
        word_next  = word;
        valid_next = word_valid;
`ifdef MUX_SCAN_PARITY_EN
        parity_next = parity;
`endif
        case (state)
            ST_IDLE: begin
                sel_next = 4'd0;
                if (start) begin
                    cnt_next   = SETTLE_LOAD;
                    shreg_next = 16'h0000;
                    state_next = step_state ? ST_SETTLE : ST_SAMPLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    sel_next   = 4'd0;
                end else if (cnt == 4'd0) begin
                    state_next = ST_SAMPLE;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    sel_next   = 4'd0;
                end else begin
                    shreg_next = captured;
                    if (sel == 4'd15) begin
                        state_next = ST_HOLD;
                        sel_next   = 4'd0;
                        word_next  = captured;
                        valid_next = 1'b1;
`ifdef MUX_SCAN_PARITY_EN
                        parity_next = ^captured;
`endif
                    end else begin
                        sel_next   = sel + 4'd1;
                        cnt_next   = SETTLE_LOAD;
                        state_next = step_state ? ST_SETTLE : ST_SAMPLE;
                    end
                end
            end
            ST_HOLD: begin
                if (word_ready) begin
                    valid_next = 1'b0;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                sel_next   = 4'd0;
            end
        endcase
    end

    // State and datapath registers; reset discards any scan in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            sel        <= 4'd0;
            cnt        <= 4'd0;
            shreg      <= 16'h0000;
            word       <= 16'h0000;
            word_valid <= 1'b0;
        end else begin
            state      <= state_next;
            sel        <= sel_next;
            cnt        <= cnt_next;
            shreg      <= shreg_next;
            word       <= word_next;
            word_valid <= valid_next;
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    // Parity of the captured word, registered alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            parity <= 1'b0;
        end else begin
            parity <= parity_next;
        end
    end
`endif

endmodule

// File: doc/mux16_scan_ctrl.md
# mux16_scan_ctrl

Sequential scan controller that sits directly upstream of the 16-to-1 mux (`mux_16to1`). On a start request it steps the mux select from 0 to 15 and waits a configurable settle time on each step. It samples the mux output at the end of each step and presents the 16 captured bits as one word on a valid/ready handshake. It lets downstream logic read back a 16-bit source through a single-bit mux path.

## Interface
- `SETTLE_CYCLES`, default 1: idle cycles per select step before sampling; legal range 0..15.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  begin a scan; honoured only in IDLE.
- `abort`  input  1  cancel an in-progress scan; no word is produced.
- `mux_out`  input  1  connects to `MuxOut` of `mux_16to1`.
- `sel`  output  4  drives `sel` of `mux_16to1`.
- `busy`  output  1  high in SETTLE and SAMPLE.
- `word`  output  16  captured word; bit i equals `mux_out` sampled while `sel` = i.
- `word_valid`  output  1  `word` is available; held until accepted.
- `word_ready`  input  1  consumer accepts `word`.
- `parity`  output  1  present only with `MUX_SCAN_PARITY_EN` (see Configuration).

## Operation
- States: IDLE, SETTLE, SAMPLE, HOLD.
- IDLE
  - `sel` = 0.
  - If `start`: go to SETTLE if `SETTLE_CYCLES` > 0, else to SAMPLE. Load the settle counter with `SETTLE_CYCLES`−1 and clear the internal shift register.
- SETTLE
  - Decrement the settle counter.
  - When the counter is 0, go to SAMPLE.
- SAMPLE
  - At the clock edge, store `mux_out` into internal bit [`sel`].
  - If `sel` = 15: go to HOLD, copy the internal register to `word`, and set `word_valid`=1.
  - Otherwise: `sel` <= `sel`+1, reload the settle counter, and go to SETTLE (or stay in SAMPLE when `SETTLE_CYCLES` = 0).
- HOLD
  - If `word_ready`: clear `word_valid` and go to IDLE.
  - `start` and `abort` are ignored in HOLD.
- `abort` in SETTLE or SAMPLE
  - Next state is IDLE and `sel` returns to 0.
  - The bit in flight is not captured.
  - `word`, `word_valid` and `parity` are unchanged.
  - `abort` has priority over the SAMPLE transition.
- `start` outside IDLE is ignored. A `start` held high in IDLE begins a scan every time the block returns to IDLE.
- `word` changes only on scan completion. It remains stable in IDLE after acceptance, so the last word stays readable.
- Out-of-range `SETTLE_CYCLES` (> 15) is a configuration error; behaviour is undefined.

## Timing
- Reset values: `sel`=0, `busy`=0, `word`=16'h0000, `word_valid`=0, `parity`=0; state IDLE. Reset mid-scan or in HOLD discards all progress.
- Each select step lasts `SETTLE_CYCLES`+1 cycles. `sel` is stable for the whole step.
- `mux_out` is sampled at the final edge of the step. The mux path must settle within `SETTLE_CYCLES`+1 clock periods.
- Latency: `start` sampled at edge E0 gives `word_valid`=1 after edge E0 + 16·(`SETTLE_CYCLES`+1).
- `busy` rises after E0 and falls on the same edge that `word_valid` rises.
- Handshake: transfer occurs on an edge where `word_valid` and `word_ready` are both 1. `word_valid` is low the following cycle.
- `word_ready` while `word_valid`=0 has no effect.
- Minimum start-to-start period is 16·(`SETTLE_CYCLES`+1)+2 cycles with `word_ready` tied high.

## Configuration
- `MUX_SCAN_PARITY_EN` defined:
  - `parity` port exists and is registered with `word`: XOR of all 16 captured bits, so it is 1 when the number of ones is odd.
  - `parity` updates on the same edge as `word`; reset value 0.
- Undefined: `parity` port and its logic are absent. All other behaviour is identical.

## Test plan
- Source 16'hC3B4 on the mux inputs, `SETTLE_CYCLES`=1, pulse `start` -> `sel` steps 0..15, two cycles per value; `word_valid` rises 32 cycles after the start edge with `word`=16'hC3B4; with the macro defined, `parity`=0.
- Source 16'hC3BF, `SETTLE_CYCLES`=0, `word_ready` tied high -> `word`=16'hC3BF after 16 cycles; `word_valid` high for exactly one cycle; `parity`=1.
- Hold `word_ready`=0 for 10 cycles after completion while pulsing `start` -> `word_valid` and `word` stay stable and no new scan begins; raise `word_ready` -> IDLE next cycle.
- Assert `abort` while `sel`=7 in SAMPLE -> IDLE next cycle with `sel`=0 and `busy`=0; `word` keeps the previous value and `word_valid` stays 0.
- Assert `reset` with `sel`=10 mid-scan, then restart with source 16'h0001 -> all outputs at reset values; the new scan yields `word`=16'h0001.
- Hold `start` high continuously with `word_ready` high -> back-to-back scans, each separated by exactly one IDLE cycle.
